operand_deserializer: RTL and testbench

Bit-serial to word-parallel operand loader that sits directly upstream of the ripple-carry adder stage. It accepts one bit of operand A and one bit of operand B per accepted cycle, LSB first, and assembles them into `D_N`-bit words. It presents each completed word pair to the adder with a valid/ready handshake and holds it stable until the adder side takes it.

---
 rtl/operand_deserializer.sv | 129 ++++++++++++
 tb/tb_operand_deserializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_deserializer.sv
// operand_deserializer: bit-serial (LSB first) to word-parallel operand loader
// feeding the ripple-carry adder stage through a valid/ready handshake.
// Optional build macro DESER_DBUF_EN adds a holding register behind the shift
// register so filling can overlap with a pending output pair.
module operand_deserializer #(
  parameter int unsigned D_N = 32
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic                     w_in_vld,
  input  logic                     w_a,
  input  logic                     w_b,
  output logic                     w_in_rdy,
  output logic                     w_out_vld,
  input  logic                     w_out_rdy,
  output logic [D_N-1:0]           w_opa,
  output logic [D_N-1:0]           w_opb,
  output logic [$clog2(D_N+1)-1:0] w_cnt
);

  localparam int unsigned CNT_W = $clog2(D_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(D_N);

  // S_FULL means a completed pair is presented on w_opa/w_opb
  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [D_N-1:0]   sa_q;
  logic [D_N-1:0]   sb_q;
  logic [D_N-1:0]   sa_d;
  logic [D_N-1:0]   sb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             word_done;
  logic             xfer;
  logic             load;

  assign w_cnt = cnt_q;

  // Handshake decode, shift-register next value and bit counter next value
  always_comb begin
    accept    = w_in_vld & w_in_rdy;
    word_done = accept & (cnt_q == CNT_LAST);
    xfer      = (state_q == S_FULL) & w_out_rdy;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    if (accept) begin
      sa_d = {w_a, sa_q[D_N-1:1]};
      sb_d = {w_b, sb_q[D_N-1:1]};
    end
`ifdef DESER_DBUF_EN
    // A finished word enters hold when hold is free or draining this edge;
    // a parked word (cnt == D_N) follows as soon as hold drains.
    load = (word_done & ((state_q == S_FILL) | xfer)) |
           ((cnt_q == CNT_FULL) & xfer);
    if (load) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`else
    // Single buffer: counter parks at D_N while the pair is presented
    load = word_done;
    if (xfer) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  // State register
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (load) state_d = S_FULL;
      S_FULL:  if (xfer && !load) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Output decode: readiness never looks at w_in_vld, validity never at w_out_rdy
  always_comb begin
    w_out_vld = 1'b0;
    w_in_rdy  = 1'b0;
    w_out_vld = (state_q == S_FULL);
`ifdef DESER_DBUF_EN
    w_in_rdy  = ~w_rst & (cnt_q != CNT_FULL);
`else
    w_in_rdy  = ~w_rst & (state_q == S_FILL);
`endif
  end

  // Datapath registers; output words change only on a load edge
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sa_q  <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
      w_opa <= '0;
      w_opb <= '0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      if (load) begin
        w_opa <= sa_d;
        w_opb <= sb_d;
      end
    end
  end

endmodule

// File: tb/tb_operand_deserializer.sv
// Self-checking bench for operand_deserializer (D_N = 32). Inputs are driven
// and outputs sampled on the falling edge; expected pairs go through a queue.
module tb_operand_deserializer;

  localparam int unsigned D_N   = 32;
  localparam int unsigned CNT_W = $clog2(D_N + 1);

  logic             w_clk = 1'b0;
  logic             w_rst;
  logic             w_in_vld;
  logic             w_a;
  logic             w_b;
  logic             w_in_rdy;
  logic             w_out_vld;
  logic             w_out_rdy;
  logic [D_N-1:0]   w_opa;
  logic [D_N-1:0]   w_opb;
  logic [CNT_W-1:0] w_cnt;

  int passed   = 0;
  int total    = 0;
  int xfer_cnt = 0;
  int cyc      = 0;

  logic [D_N-1:0] exp_a_q[$];
  logic [D_N-1:0] exp_b_q[$];
  logic [D_N-1:0] obs_a_q[$];
  logic [D_N-1:0] obs_b_q[$];
  int             xfer_cyc_q[$];

  operand_deserializer #(.D_N(D_N)) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_in_vld  (w_in_vld),
    .w_a       (w_a),
    .w_b       (w_b),
    .w_in_rdy  (w_in_rdy),
    .w_out_vld (w_out_vld),
    .w_out_rdy (w_out_rdy),
    .w_opa     (w_opa),
    .w_opb     (w_opb),
    .w_cnt     (w_cnt)
  );

  always #5 w_clk = ~w_clk;

  // Transfer monitor: records every handshake the adder side completes
  always @(posedge w_clk) begin
    cyc++;
    if (!w_rst && w_out_vld === 1'b1 && w_out_rdy === 1'b1) begin
      xfer_cnt++;
      xfer_cyc_q.push_back(cyc);
      obs_a_q.push_back(w_opa);
      obs_b_q.push_back(w_opb);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Drive n bit pairs LSB first; optional idle cycle after each pair.
  // With tail set, returns at the falling edge right after the last accept.
  task automatic drive_bits(input logic [D_N-1:0] a, input logic [D_N-1:0] b,
                            input int n, input bit gaps, input bit tail);
    logic [CNT_W-1:0] want;
    for (int i = 0; i < n; i++) begin
      @(negedge w_clk);
      if (gaps && i > 0) begin
        total++;
        if (w_cnt !== CNT_W'(i)) $display("FAIL cnt_idle: got %0d want %0d", w_cnt, i);
        else passed++;
      end
      total++;
      if (w_in_rdy !== 1'b1) $display("FAIL in_rdy_fill: bit %0d got %b want 1", i, w_in_rdy);
      else passed++;
`ifndef DESER_DBUF_EN
      total++;
      if (w_out_vld !== 1'b0) $display("FAIL out_vld_fill: bit %0d got %b want 0", i, w_out_vld);
      else passed++;
`endif
      w_in_vld = 1'b1;
      w_a      = a[i];
      w_b      = b[i];
      if (gaps) begin
        @(negedge w_clk);
        w_in_vld = 1'b0;
        w_a      = 1'($urandom);
        w_b      = 1'($urandom);
        want     = CNT_W'(i + 1);
`ifdef DESER_DBUF_EN
        if (i + 1 == D_N) want = '0;
`endif
        total++;
        if (w_cnt !== want) $display("FAIL cnt_accept: got %0d want %0d", w_cnt, want);
        else passed++;
      end
    end
    if (!gaps && tail) begin
      @(negedge w_clk);
      w_in_vld = 1'b0;
    end
  endtask

  // Pop the expected pair, hold it for `hold` extra cycles, then take it
  task automatic expect_word(input int hold, input bit poke);
    logic [D_N-1:0] ea;
    logic [D_N-1:0] eb;
    int x0;
    if (exp_a_q.size() == 0) begin
      total++;
      $display("FAIL sb_empty: got 0 entries want >=1");
      return;
    end
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    x0 = xfer_cnt;
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge w_clk);
      total++;
      if (w_out_vld !== 1'b1 || w_opa !== ea || w_opb !== eb)
        $display("FAIL word_out: cyc %0d vld=%b opa=%h opb=%h want vld=1 opa=%h opb=%h",
                 k, w_out_vld, w_opa, w_opb, ea, eb);
      else passed++;
`ifndef DESER_DBUF_EN
      total++;
      if (w_in_rdy !== 1'b0 || w_cnt !== CNT_W'(D_N))
        $display("FAIL full_hold: in_rdy=%b cnt=%0d want in_rdy=0 cnt=%0d", w_in_rdy, w_cnt, D_N);
      else passed++;
      if (poke) begin
        w_in_vld = 1'b1;
        w_a      = 1'($urandom);
        w_b      = 1'($urandom);
      end
`endif
      w_out_rdy = (k == hold);
    end
    @(negedge w_clk);
    total++;
    if (w_out_vld !== 1'b0 || xfer_cnt != x0 + 1)
      $display("FAIL word_xfer: vld=%b transfers=%0d want vld=0 transfers=%0d",
               w_out_vld, xfer_cnt - x0, 1);
    else passed++;
    total++;
    if (w_cnt !== '0) $display("FAIL cnt_after: got %0d want 0", w_cnt);
    else passed++;
    w_in_vld = 1'b0;
  endtask

  task automatic test_reset();
    w_rst = 1'b1; w_in_vld = 1'b1; w_a = 1'b0; w_b = 1'b0; w_out_rdy = 1'b0;
    @(negedge w_clk);
    #1;
    total++;
    if (w_in_rdy !== 1'b0) $display("FAIL rst_in_rdy: got %b want 0", w_in_rdy);
    else passed++;
    @(negedge w_clk);
    w_rst = 1'b0; w_in_vld = 1'b0;
    #1;
    total++;
    if (w_out_vld !== 1'b0 || w_cnt !== '0 || w_opa !== '0 || w_opb !== '0 || w_in_rdy !== 1'b1)
      $display("FAIL rst_state: vld=%b cnt=%0d opa=%h opb=%h rdy=%b want 0 0 0 0 1",
               w_out_vld, w_cnt, w_opa, w_opb, w_in_rdy);
    else passed++;
  endtask

  task automatic test_basic();
    w_out_rdy = 1'b1;
    exp_a_q.push_back(32'd3);
    exp_b_q.push_back(32'd10);
    drive_bits(32'd3, 32'd10, D_N, 1'b0, 1'b1);
    expect_word(0, 1'b0);
  endtask

  task automatic test_backpressure();
    w_out_rdy = 1'b0;
    exp_a_q.push_back(32'd3);
    exp_b_q.push_back(32'd10);
    drive_bits(32'd3, 32'd10, D_N, 1'b0, 1'b1);
    expect_word(5, 1'b1);
  endtask

  task automatic test_gaps();
    w_out_rdy = 1'b1;
    exp_a_q.push_back(32'hFFFF_FFFF);
    exp_b_q.push_back(32'h8000_0001);
    drive_bits(32'hFFFF_FFFF, 32'h8000_0001, D_N, 1'b1, 1'b1);
    expect_word(0, 1'b0);
  endtask

  task automatic test_reset_midword();
    w_out_rdy = 1'b1;
    drive_bits(32'hA5A5_5A5A, 32'h0F0F_F0F0, 17, 1'b0, 1'b1);
    total++;
    if (w_cnt !== CNT_W'(17)) $display("FAIL cnt_partial: got %0d want 17", w_cnt);
    else passed++;
    w_rst = 1'b1; w_in_vld = 1'b1; w_a = 1'b1; w_b = 1'b1;
    #1;
    total++;
    if (w_in_rdy !== 1'b0) $display("FAIL rst_mid_rdy: got %b want 0", w_in_rdy);
    else passed++;
    @(negedge w_clk);
    w_rst = 1'b0; w_in_vld = 1'b0;
    total++;
    if (w_cnt !== '0 || w_out_vld !== 1'b0 || w_opa !== '0 || w_opb !== '0)
      $display("FAIL rst_mid_state: cnt=%0d vld=%b opa=%h opb=%h want all 0",
               w_cnt, w_out_vld, w_opa, w_opb);
    else passed++;
    exp_a_q.push_back(32'h1234_5678);
    exp_b_q.push_back(32'hFEDC_BA98);
    drive_bits(32'h1234_5678, 32'hFEDC_BA98, D_N, 1'b0, 1'b1);
    expect_word(0, 1'b0);
  endtask

  task automatic test_reset_full();
    int x0;
    w_out_rdy = 1'b0;
    drive_bits(32'hCAFE_F00D, 32'h0BAD_BEEF, D_N, 1'b0, 1'b1);
    total++;
    if (w_out_vld !== 1'b1 || w_opa !== 32'hCAFE_F00D)
      $display("FAIL full_pre_rst: vld=%b opa=%h want vld=1 opa=cafef00d", w_out_vld, w_opa);
    else passed++;
    x0 = xfer_cnt;
    w_rst = 1'b1; w_out_rdy = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0; w_out_rdy = 1'b0;
    total++;
    if (w_out_vld !== 1'b0 || xfer_cnt != x0 || w_opa !== '0 || w_cnt !== '0)
      $display("FAIL rst_full: vld=%b transfers=%0d opa=%h cnt=%0d want 0 0 0 0",
               w_out_vld, xfer_cnt - x0, w_opa, w_cnt);
    else passed++;
  endtask

`ifdef DESER_DBUF_EN
  task automatic test_dbuf();
    logic [D_N-1:0] ea;
    logic [D_N-1:0] eb;
    int c0;
    xfer_cyc_q.delete(); obs_a_q.delete(); obs_b_q.delete();
    w_out_rdy = 1'b1;
    for (int w = 0; w < 3; w++) begin
      exp_a_q.push_back(D_N'(w + 1));
      exp_b_q.push_back(D_N'(w + 4));
    end
    for (int w = 0; w < 3; w++)
      drive_bits(D_N'(w + 1), D_N'(w + 4), D_N, 1'b0, (w == 2));
    repeat (3) @(negedge w_clk);
    total++;
    if (xfer_cyc_q.size() != 3) $display("FAIL dbuf_count: got %0d want 3", xfer_cyc_q.size());
    else passed++;
    c0 = 0;
    for (int w = 0; w < 3; w++) begin
      if (obs_a_q.size() == 0 || exp_a_q.size() == 0) break;
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      total++;
      if (obs_a_q[0] !== ea || obs_b_q[0] !== eb)
        $display("FAIL dbuf_word: got %h/%h want %h/%h", obs_a_q[0], obs_b_q[0], ea, eb);
      else passed++;
      if (w > 0) begin
        total++;
        if (xfer_cyc_q[0] - c0 != D_N)
          $display("FAIL dbuf_spacing: got %0d want %0d", xfer_cyc_q[0] - c0, D_N);
        else passed++;
      end
      c0 = xfer_cyc_q.pop_front();
      void'(obs_a_q.pop_front()); void'(obs_b_q.pop_front());
    end
    exp_a_q.delete(); exp_b_q.delete();
    w_out_rdy = 1'b0;
    drive_bits(D_N'(7), D_N'(9), D_N, 1'b0, 1'b0);
    drive_bits(D_N'(8), D_N'(10), D_N, 1'b0, 1'b1);
    total++;
    if (w_in_rdy !== 1'b0 || w_cnt !== CNT_W'(D_N) || w_out_vld !== 1'b1 || w_opa !== D_N'(7))
      $display("FAIL dbuf_stall: rdy=%b cnt=%0d vld=%b opa=%h want 0 %0d 1 7",
               w_in_rdy, w_cnt, w_out_vld, w_opa, D_N);
    else passed++;
    w_out_rdy = 1'b1;
    @(negedge w_clk);
    total++;
    if (w_opa !== D_N'(8) || w_opb !== D_N'(10) || w_cnt !== '0 || w_out_vld !== 1'b1)
      $display("FAIL dbuf_drain: opa=%h opb=%h cnt=%0d vld=%b want 8 a 0 1",
               w_opa, w_opb, w_cnt, w_out_vld);
    else passed++;
    @(negedge w_clk);
    w_out_rdy = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_midword();
    test_reset_full();
`ifdef DESER_DBUF_EN
    test_dbuf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
